// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage no-forwarding pipeline: RAW hazard
// detection, EX redirect flushing and freeze while a data-memory access waits.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 16,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic                  id_rs1_re_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs2_re_i,
    input  logic [REG_ADDR_W-1:0] ex_wr_i,
    input  logic                  ex_we_i,
    input  logic [REG_ADDR_W-1:0] mem_wr_i,
    input  logic                  mem_we_i,
    input  logic [REG_ADDR_W-1:0] wb_wr_i,
    input  logic                  wb_we_i,
    input  logic                  ex_redirect_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  pc_stall_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_stall_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_stall_o,
    output logic                  mem_wb_flush_o,
    output logic                  mem_err_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);
    localparam int WCNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {RUN = 2'd0, HAZ = 2'd1, MWAIT = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
    logic               hz, mw, freeze, err;

    // WB destinations count: the register file has no write-through.
    function automatic logic src_hz(input logic [REG_ADDR_W-1:0] s, input logic re);
        return re && (s != '0) &&
               ((ex_we_i && ex_wr_i == s) || (mem_we_i && mem_wr_i == s) ||
                (wb_we_i && wb_wr_i == s));
    endfunction

    assign hz = src_hz(id_rs1_i, id_rs1_re_i) || src_hz(id_rs2_i, id_rs2_re_i);
    assign mw = mem_req_i && !mem_ack_i;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        freeze    = 1'b0;
        err       = 1'b0;
        case (state)
            MWAIT: begin
                if (mem_ack_i) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end else if (wcnt == WCNT_W'(MAX_WAIT - 1)) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                    freeze    = 1'b1;
                    err       = 1'b1;
                end else begin
                    wcnt_nxt  = wcnt + 1'b1;
                    freeze    = 1'b1;
                end
            end
            default: begin
                if (mw) begin
                    state_nxt = MWAIT;
                    wcnt_nxt  = WCNT_W'(1);
                    freeze    = 1'b1;
                end else if (ex_redirect_i) begin
                    state_nxt = RUN;
                end else if (hz) begin
                    state_nxt = HAZ;
                end else begin
                    state_nxt = RUN;
                end
            end
        endcase
    end

    // Outputs are forced low while reset is held, even mid-access.
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        mem_err_o      = 1'b0;
        if (rst_n_i) begin
            mem_err_o = err;
            if (freeze) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
                mem_wb_flush_o = 1'b1;
            end else if (ex_redirect_i) begin
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
            end else if (hz) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= RUN;
            wcnt        <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (pc_stall_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (if_id_flush_o && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

    assign state_o = state;

endmodule
